// File: rtl/slow_pkg.sv
// Shared definitions for the slow-access timing window.
// Holds the window state encoding, the default tick divider and the
// timeout field width used by slow_window and slow_prescaler.
package slow_pkg;

  // Default number of clock cycles per timeout tick
  localparam int TICK_DIV_DEFAULT = 16;

  // Width of the slow timeout field from the configuration register
  localparam int TIMEOUT_W = 4;

  // Window state encoding (IDLE, ARM, HOLD)
  typedef logic [1:0] slow_state_t;
  localparam slow_state_t ST_IDLE = 2'd0;
  localparam slow_state_t ST_ARM  = 2'd1;
  localparam slow_state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/slow_prescaler.sv
// Tick prescaler for the slow window hold phase.
// Counts 0..TICK_DIV-1 while enabled.  Tick is high during the cycle in
// which the count wraps back to 0.  A synchronous clear takes priority
// over the enable and forces the count to 0.
module slow_prescaler
  import slow_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick does not depend on clr so the FSM can use it without a loop
  assign tick = en & (cnt_q == LAST);

  // Next count: clear wins, otherwise advance and wrap while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/slow_window.sv
// Slow-access timing window generator.
// Watches bus cycles and, when an enabled slow device is accessed, holds
// SlowReq (and optionally ClkGateReq) for the rest of the access plus
// SlowTimeout prescaled ticks.  SlowBusy flags the post-access hold phase.
// Optional feature macro: SLOW_SND_EN (sound chip select joins the hit
// decode when defined; otherwise SndCS/SlowSnd are ignored).
module slow_window
  import slow_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 POR,
  input  logic                 BACT,
  input  logic                 IACK,
  input  logic                 VIACS,
  input  logic                 IWMCS,
  input  logic                 SCCCS,
  input  logic                 SCSICS,
  input  logic                 SndCS,
  input  logic                 SlowIACK,
  input  logic                 SlowVIA,
  input  logic                 SlowIWM,
  input  logic                 SlowSCC,
  input  logic                 SlowSCSI,
  input  logic                 SlowSnd,
  input  logic                 SlowClockGate,
  input  logic [TIMEOUT_W-1:0] SlowTimeout,
  output logic                 SlowReq,
  output logic                 ClkGateReq,
  output logic                 SlowBusy
);

  slow_state_t          state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 bactr_q, bactr_d;
  logic                 slow_req_q, slow_req_d;
  logic                 clk_gate_q, clk_gate_d;
  logic                 busy_q, busy_d;

  logic start_cyc;
  logic snd_term;
  logic hit;
  logic tick;
  logic presc_clr;
  logic presc_en;

`ifdef SLOW_SND_EN
  assign snd_term = SndCS & SlowSnd;
`else
  logic unused_snd;
  assign unused_snd = SndCS ^ SlowSnd;
  assign snd_term   = 1'b0;
`endif

  // A hit needs a fresh bus cycle to an enabled slow device
  assign start_cyc = BACT & ~bactr_q;
  assign hit = start_cyc & ((IACK   & SlowIACK) |
                            (VIACS  & SlowVIA)  |
                            (IWMCS  & SlowIWM)  |
                            (SCCCS  & SlowSCC)  |
                            (SCSICS & SlowSCSI) |
                            snd_term);

  // Prescaler restarts on every HOLD entry and idles at 0 elsewhere
  assign presc_en  = (state_q == ST_HOLD);
  assign presc_clr = (state_q != ST_HOLD) | (state_d != ST_HOLD);

  slow_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (CLK),
    .rst  (POR),
    .clr  (presc_clr),
    .en   (presc_en),
    .tick (tick)
  );

  // Window FSM and hold counter; a retrigger hit beats expiry
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == ST_HOLD) ? cnt_q : '0;
    bactr_d = BACT;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (!BACT) begin
          if (SlowTimeout != '0) begin
            state_d = ST_HOLD;
            cnt_d   = SlowTimeout;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (hit) begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_q - TIMEOUT_W'(1);
          if (cnt_q == TIMEOUT_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered copies of the next-state decode
  always_comb begin
    slow_req_d = (state_d != ST_IDLE);
    clk_gate_d = (state_d != ST_IDLE) & SlowClockGate;
    busy_d     = (state_d == ST_HOLD);
  end

  // State, counter, BACT history and output registers
  always_ff @(posedge CLK) begin
    if (POR) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bactr_q    <= 1'b0;
      slow_req_q <= 1'b0;
      clk_gate_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bactr_q    <= bactr_d;
      slow_req_q <= slow_req_d;
      clk_gate_q <= clk_gate_d;
      busy_q     <= busy_d;
    end
  end

  assign SlowReq    = slow_req_q;
  assign ClkGateReq = clk_gate_q;
  assign SlowBusy   = busy_q;

endmodule

// File: doc/slow_window.md
# slow_window

Timing-window generator downstream of the slow-access configuration register. It takes the per-device slow-enable bits and the 4-bit slow timeout from that register and watches bus cycles. When an enabled slow device is accessed, it asserts a registered slow request, plus an optional clock-gate request. The request holds for the rest of the access and then for a programmable number of prescaled ticks, so the accelerator runs at stock speed around timing-sensitive peripherals.

## Interface
- TICK_DIV, 16, CLK cycles per timeout tick (≥2)
- CLK  in  1  system clock, all state on rising edge
- POR  in  1  synchronous, active-high reset
- BACT  in  1  bus cycle active (CPU access in progress)
- IACK  in  1  current cycle is interrupt acknowledge
- VIACS, IWMCS, SCCCS, SCSICS, SndCS  in  1 each  device selects for current cycle
- SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd, SlowClockGate  in  1 each  config enables from the configuration register
- SlowTimeout  in  4  hold length in ticks after the access ends
- SlowReq  out  1  force slow CPU timing
- ClkGateReq  out  1  request fast-clock gating
- SlowBusy  out  1  window in HOLD phase (debug/status)

## Operation
- States: IDLE, ARM, HOLD. Reset: IDLE, SlowReq=0, ClkGateReq=0, SlowBusy=0, tick counter=0, prescaler=0, BACTr=0.
- BACTr is BACT registered. StartCyc = BACT & !BACTr.
- Hit = StartCyc & OR of (IACK&SlowIACK, VIACS&SlowVIA, IWMCS&SlowIWM, SCCCS&SlowSCC, SCSICS&SlowSCSI, SndCS&SlowSnd). Enables are sampled only in the Hit cycle.
- IDLE: Hit → ARM.
- ARM: stay while BACT=1. On BACT=0: if SlowTimeout≠0 → HOLD, load Cnt=SlowTimeout, clear prescaler. Else → IDLE.
- HOLD: prescaler counts 0..TICK_DIV-1, and a tick occurs when it wraps to 0. On each tick Cnt decrements, and Cnt reaching 0 on a tick → IDLE. A Hit in HOLD → ARM (retrigger); the counter is reloaded on the next ARM→HOLD transition.
- Simultaneous Hit and expiry tick: Hit wins → ARM.
- SlowTimeout changes during HOLD have no effect until the next load.
- SlowReq is registered = (next state ≠ IDLE).
- ClkGateReq is registered = next SlowReq & SlowClockGate. SlowClockGate is sampled live, so clearing it drops ClkGateReq on the next edge.
- SlowBusy is registered = (next state == HOLD).
- POR in any state → IDLE, with all outputs 0 at the next edge.
- Prescaler and Cnt are idle (held 0) outside HOLD.

## Timing
- Hit in cycle n → SlowReq=1 from edge n+1.
- BACT low first sampled in cycle m → HOLD from edge m+1.
- HOLD lasts exactly SlowTimeout×TICK_DIV cycles. SlowReq falls at edge m+1+SlowTimeout×TICK_DIV.
- SlowTimeout=0 → SlowReq falls at edge m+1.
- Back-to-back cycles where BACT never drops stay in ARM. Only a rising BACT edge can generate a Hit.
- Prescaler width: ceil(log2(TICK_DIV)). Cnt width: 4, with no underflow (load is nonzero, exit at 0).

## Configuration
- SLOW_SND_EN: defined → SndCS&SlowSnd participates in Hit.
- Not defined → the sound term is constant 0. SndCS and SlowSnd remain ports but are unused, and all other behaviour is identical.

## Structure
- Shared package slow_pkg holds:
  - state enum (IDLE, ARM, HOLD)
  - TICK_DIV default
  - timeout width constant (4)
- One sub-module, slow_prescaler: TICK_DIV counter with synchronous clear and enable, one-cycle Tick output. Instantiated once, cleared on ARM→HOLD, enabled in HOLD.
- Hit decode, FSM and Cnt stay in slow_window.

## Test plan
- Reset: POR=1 for 3 cycles mid-HOLD → IDLE next edge, SlowReq=ClkGateReq=SlowBusy=0.
- TICK_DIV=4, SlowVIA=1, SlowTimeout=3, VIACS access with BACT high 5 cycles:
  - SlowReq rises 1 cycle after BACT rises.
  - SlowReq holds 5 cycles, then 12 more, and falls at edge m+13.
- SlowSCC=0, SCCCS access → SlowReq stays 0. With SlowSCC=1 and SlowTimeout=0 → SlowReq high exactly for BACT duration +1 edge, SlowBusy never 1.
- Retrigger: second VIACS hit 5 cycles into HOLD → ARM, then a full 12-cycle HOLD after the second access ends. A hit coinciding with the final tick still → ARM.
- SlowClockGate toggled 1→0 during HOLD → ClkGateReq falls next edge, SlowReq unaffected.
- SndCS hit with SlowSnd=1 → SlowReq=1 with SLOW_SND_EN defined, SlowReq=0 without it.
